mdu_ctrl: RTL and testbench

- Multi-cycle multiply/divide sequencer beside the Execute-stage ALU.
- Owns the architectural HI/LO registers.
- Runs MULT/MULTU/DIV/DIVU iteratively and handles MTHI/MTLO.
- Raises a pipeline stall while a new MDU op, or an HI/LO read, collides with an op in flight.

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mdu_step.sv | 40 ++++
 rtl/mdu_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared operation/state encodings and constants for the
// multiply/divide unit (mdu_ctrl and mdu_step).
package mdu_pkg;

   localparam int MDU_WIDTH = 32;

   // Quotient reported for any divide by zero.
   localparam logic [MDU_WIDTH-1:0] MDU_DIV0_LO = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      MDU_MULT  = 3'd0,
      MDU_MULTU = 3'd1,
      MDU_DIV   = 3'd2,
      MDU_DIVU  = 3'd3,
      MDU_MTHI  = 3'd4,
      MDU_MTLO  = 3'd5
   } mdu_op_e;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'd0,
      MDU_CALC = 2'd1,
      MDU_FIN  = 2'd2
   } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one combinational radix-2 iteration of the MDU datapath.
// Multiply: shift-add, accumulator = {partial product high, multiplier bits}.
// Divide:   restoring shift-subtract, accumulator = {remainder, quotient bits}.
module mdu_step
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic [2*WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0]   operand_i,
   input  logic               div_i,
   output logic [2*WIDTH-1:0] acc_o,
   output logic               qbit_o
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] cand;
   logic [WIDTH:0] diff;

   // Compute both step variants and select by mode; quotient bit goes out
   // separately, the accumulator LSB is left free for it in divide mode.
   always_comb begin
      // NOTE: every variable assigned in always_comb gets a value on every
      // path (defaults first), otherwise a latch is inferred.
      acc_o  = '0;
      qbit_o = 1'b0;
      sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} +
               {1'b0, ({WIDTH{acc_i[0]}} & operand_i)};
      cand   = acc_i[2*WIDTH-1:WIDTH-1];
      diff   = cand - {1'b0, operand_i};
      if (div_i) begin
         qbit_o = ~diff[WIDTH];
         acc_o  = {(qbit_o ? diff[WIDTH-1:0] : cand[WIDTH-1:0]),
                   acc_i[WIDTH-2:0], 1'b0};
      end else begin
         acc_o  = {sum, acc_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide sequencer that owns HI/LO.
// IDLE -> CALC (ITER steps) -> FIN (sign fixup, HI/LO write) -> IDLE.
// Optional build macro MDU_FAST_MUL_EN: MULT/MULTU use a single-cycle
// product and go IDLE -> FIN directly; divide timing is unchanged.
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH,
   parameter int ITER  = WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] op1_i,
   input  logic [WIDTH-1:0] op2_i,
   input  logic             rd_hilo_i,
   input  logic             flush_i,
   output logic             stall_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITER - 1);
   localparam logic [WIDTH-1:0] DIV0_LO  =
      (WIDTH == MDU_WIDTH) ? MDU_DIV0_LO : {WIDTH{1'b1}};

   mdu_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [WIDTH-1:0]   op1_q, op1_d;
   logic               div_q, div_d;
   logic               sgn_q, sgn_d;
   logic               s1_q, s1_d;
   logic               s2_q, s2_d;
   logic               div0_q, div0_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic               op_signed;
   logic [WIDTH-1:0]   abs1, abs2;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;
   logic [2*WIDTH-1:0] step_acc;
   logic               step_qbit;

   mdu_step #(.WIDTH(WIDTH)) u_step (
      .acc_i     (acc_q),
      .operand_i (opnd_q),
      .div_i     (div_q),
      .acc_o     (step_acc),
      .qbit_o    (step_qbit)
   );

   // Operand magnitudes for the incoming op and sign fixup of the finished one.
   always_comb begin
      op_signed = (op_i == MDU_MULT) || (op_i == MDU_DIV);
      abs1      = (op_signed && op1_i[WIDTH-1]) ? -op1_i : op1_i;
      abs2      = (op_signed && op2_i[WIDTH-1]) ? -op2_i : op2_i;
      prod_fix  = (sgn_q && (s1_q ^ s2_q)) ? -acc_q : acc_q;
      quot_fix  = (sgn_q && (s1_q ^ s2_q)) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fix   = (sgn_q && s1_q) ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   end

   // Next-state and datapath: accept ops in IDLE, iterate in CALC, write in FIN.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      op1_d   = op1_q;
      div_d   = div_q;
      sgn_d   = sgn_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      div0_d  = div0_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         MDU_IDLE: begin
            if (start_i && !flush_i) begin
               case (op_i)
                  MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                     div_d  = op_i[1];
                     sgn_d  = op_signed;
                     s1_d   = op_signed & op1_i[WIDTH-1];
                     s2_d   = op_signed & op2_i[WIDTH-1];
                     div0_d = (op2_i == '0);
                     op1_d  = op1_i;
                     cnt_d  = CNT_LOAD;
                     state_d = MDU_CALC;
                     if (op_i[1]) begin
                        acc_d  = {{WIDTH{1'b0}}, abs1};
                        opnd_d = abs2;
                     end else begin
`ifdef MDU_FAST_MUL_EN
                        acc_d   = {{WIDTH{1'b0}}, abs1} * {{WIDTH{1'b0}}, abs2};
                        opnd_d  = abs1;
                        state_d = MDU_FIN;
`else
                        acc_d  = {{WIDTH{1'b0}}, abs2};
                        opnd_d = abs1;
`endif
                     end
                  end
                  MDU_MTHI: hi_d = op1_i;
                  MDU_MTLO: lo_d = op1_i;
                  default: ;
               endcase
            end
         end
         MDU_CALC: begin
            if (flush_i) begin
               state_d = MDU_IDLE;
            end else begin
               acc_d = {step_acc[2*WIDTH-1:1], (div_q ? step_qbit : step_acc[0])};
               if (cnt_q == '0) begin
                  state_d = MDU_FIN;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         MDU_FIN: begin
            state_d = MDU_IDLE;
            if (!flush_i) begin
               if (!div_q) begin
                  hi_d = prod_fix[2*WIDTH-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end else if (div0_q) begin
                  hi_d = op1_q;
                  lo_d = DIV0_LO;
               end else begin
                  hi_d = rem_fix;
                  lo_d = quot_fix;
               end
            end
         end
         default: state_d = MDU_IDLE;
      endcase
   end

   // State register with synchronous active-low reset; reset discards any op.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the pre-edge values regardless of statement order.
      if (!rst) begin
         state_q <= MDU_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         opnd_q  <= '0;
         op1_q   <= '0;
         div_q   <= 1'b0;
         sgn_q   <= 1'b0;
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         div0_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         op1_q   <= op1_d;
         div_q   <= div_d;
         sgn_q   <= sgn_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         div0_q  <= div0_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy_o  = (state_q != MDU_IDLE);
   assign done_o  = (state_q == MDU_FIN) && !flush_i;
   assign stall_o = busy_o & (start_i | rd_hilo_i);
   assign hi_o    = hi_q;
   assign lo_o    = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: table-driven checks of mdu_ctrl with a HI/LO scoreboard,
// plus hand-written stall, back-to-back, flush and reset sequences.
module tb_mdu_ctrl;
   import mdu_pkg::*;

   localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start_i = 1'b0;
   logic [2:0]   op_i = '0;
   logic [W-1:0] op1_i = '0;
   logic [W-1:0] op2_i = '0;
   logic         rd_hilo_i = 1'b0;
   logic         flush_i = 1'b0;
   logic         stall_o, busy_o, done_o;
   logic [W-1:0] hi_o, lo_o;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } hilo_t;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } vec_t;

   hilo_t sb_q[$];
   vec_t  vecs[12];

   always #5 clk = ~clk;

   mdu_ctrl #(.WIDTH(W), .ITER(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start_i),
      .op_i      (op_i),
      .op1_i     (op1_i),
      .op2_i     (op2_i),
      .rd_hilo_i (rd_hilo_i),
      .flush_i   (flush_i),
      .stall_o   (stall_o),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .hi_o      (hi_o),
      .lo_o      (lo_o)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge (input drive point).
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present an op for one cycle; returns in cycle T+1 of the accepting edge T.
   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      tick();
      start_i = 1'b1;
      op_i    = op;
      op1_i   = a;
      op2_i   = b;
      tick();
      start_i = 1'b0;
   endtask

   // Count cycles from T+1 until done_o; k stays -1 if the budget runs out.
   task automatic wait_done(output int k, output bit busy_ok);
      k = -1;
      busy_ok = 1'b1;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (!busy_o) busy_ok = 1'b0;
         if (done_o) begin
            k = c;
            break;
         end
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int    k, exp_lat, dones, d1, d2;
      bit    ok;
      hilo_t exp, prev;

      vecs[0]  = '{MDU_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
      vecs[1]  = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[2]  = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      vecs[3]  = '{MDU_MULT,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2};
      vecs[4]  = '{MDU_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
      vecs[5]  = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[6]  = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      vecs[7]  = '{MDU_DIVU,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF};
      vecs[8]  = '{MDU_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
      vecs[9]  = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
      vecs[10] = '{MDU_DIVU,  32'hFFFF_FFFF, 32'd16,        32'd15,        32'h0FFF_FFFF};
      vecs[11] = '{MDU_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0};

      // Reset state.
      tick();
      tick();
      @(negedge clk);
      check("reset_hi", 64'(hi_o), 64'd0);
      check("reset_lo", 64'(lo_o), 64'd0);
      check("reset_busy", 64'(busy_o), 64'd0);
      check("reset_done", 64'(done_o), 64'd0);
      tick();
      rst = 1'b1;

      // Table-driven ops with scoreboard.
      for (int i = 0; i < 12; i++) begin
         exp_lat = (vecs[i].op[1] == 1'b0) ? MUL_LAT : DIV_LAT;
         sb_q.push_back('{hi: vecs[i].hi, lo: vecs[i].lo});
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_done(k, ok);
         check($sformatf("vec%0d_done_cycle", i), 64'(k), 64'(exp_lat));
         check($sformatf("vec%0d_busy_until_done", i), 64'(ok), 64'd1);
         tick();
         @(negedge clk);
         exp = sb_q.pop_front();
         check($sformatf("vec%0d_hi", i), 64'(hi_o), 64'(exp.hi));
         check($sformatf("vec%0d_lo", i), 64'(lo_o), 64'(exp.lo));
         check($sformatf("vec%0d_busy_after", i), 64'(busy_o), 64'd0);
      end

      // MTHI / MTLO in IDLE.
      issue(MDU_MTHI, 32'h0000_ABCD, 32'd0);
      @(negedge clk);
      check("mthi_hi", 64'(hi_o), 64'h0000_ABCD);
      check("mthi_busy", 64'(busy_o), 64'd0);
      issue(MDU_MTLO, 32'h0000_5678, 32'd0);
      @(negedge clk);
      check("mtlo_lo", 64'(lo_o), 64'h0000_5678);
      check("mtlo_hi_kept", 64'(hi_o), 64'h0000_ABCD);

      // Reserved op ignored.
      issue(3'd6, 32'h1111_1111, 32'h2222_2222);
      @(negedge clk);
      check("rsvd_busy", 64'(busy_o), 64'd0);
      check("rsvd_hilo", {hi_o, lo_o}, {32'h0000_ABCD, 32'h0000_5678});

      // Flush wins over start in IDLE.
      tick();
      start_i = 1'b1; op_i = MDU_MULT; op1_i = 32'd3; op2_i = 32'd3; flush_i = 1'b1;
      tick();
      start_i = 1'b0; flush_i = 1'b0;
      @(negedge clk);
      check("idle_flush_busy", 64'(busy_o), 64'd0);

      // MFHI/MFLO during MULTU stalls from T+5 through FIN.
      sb_q.push_back('{hi: 32'd0, lo: 32'd12});
      issue(MDU_MULTU, 32'd3, 32'd4);
      ok = 1'b1;
      d1 = -1;
      for (int c = 1; c <= MUL_LAT + 1; c++) begin
         if (c == 5) rd_hilo_i = 1'b1;
         @(negedge clk);
         if (c <= MUL_LAT && stall_o !== ((c >= 5) ? 1'b1 : 1'b0)) ok = 1'b0;
         if (done_o && d1 < 0) d1 = c;
         if (c <= MUL_LAT) tick();
      end
      check("rd_stall_window", 64'(ok), 64'd1);
      check("rd_stall_done_cycle", 64'(d1), 64'(MUL_LAT));
      check("rd_stall_released", 64'(stall_o), 64'd0);
      exp = sb_q.pop_front();
      check("rd_stall_hilo", {hi_o, lo_o}, {exp.hi, exp.lo});
      rd_hilo_i = 1'b0;

      // Held second MULT accepted in the first IDLE cycle after FIN.
      sb_q.push_back('{hi: 32'd0, lo: 32'd6});
      sb_q.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFF8});
      tick();
      start_i = 1'b1; op_i = MDU_MULT; op1_i = 32'd2; op2_i = 32'd3;
      tick();
      op1_i = 32'hFFFF_FFFE; op2_i = 32'd4;
      ok = 1'b1; dones = 0; d1 = -1; d2 = -1;
      for (int c = 1; c <= 2 * MUL_LAT + 2; c++) begin
         @(negedge clk);
         if (c <= MUL_LAT && !stall_o) ok = 1'b0;
         if (done_o) begin
            if (dones == 0) d1 = c; else d2 = c;
            dones++;
         end
         if (c == MUL_LAT + 1) begin
            check("b2b_idle_no_stall", 64'(stall_o), 64'd0);
            exp = sb_q.pop_front();
            check("b2b_first_hilo", {hi_o, lo_o}, {exp.hi, exp.lo});
         end
         if (c == 2 * MUL_LAT + 2) begin
            exp = sb_q.pop_front();
            check("b2b_second_hilo", {hi_o, lo_o}, {exp.hi, exp.lo});
         end
         tick();
         if (c == MUL_LAT + 1) start_i = 1'b0;
      end
      check("b2b_stall_while_busy", 64'(ok), 64'd1);
      check("b2b_first_done", 64'(d1), 64'(MUL_LAT));
      check("b2b_second_done", 64'(d2), 64'(2 * MUL_LAT + 1));
      prev = '{hi: hi_o, lo: lo_o};

      // Flush during CALC of a DIV at T+10.
      issue(MDU_DIV, 32'd100, 32'd3);
      for (int c = 1; c < 10; c++) tick();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      @(negedge clk);
      check("calc_flush_idle", 64'(busy_o), 64'd0);
      dones = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done_o) dones++;
         tick();
      end
      check("calc_flush_no_done", 64'(dones), 64'd0);
      check("calc_flush_hilo", {hi_o, lo_o}, {prev.hi, prev.lo});

      // Flush in FIN suppresses done_o and the HI/LO write.
      issue(MDU_DIVU, 32'd9, 32'd2);
      for (int c = 1; c < DIV_LAT; c++) tick();
      flush_i = 1'b1;
      @(negedge clk);
      check("fin_flush_busy", 64'(busy_o), 64'd1);
      check("fin_flush_done", 64'(done_o), 64'd0);
      tick();
      flush_i = 1'b0;
      @(negedge clk);
      check("fin_flush_idle", 64'(busy_o), 64'd0);
      check("fin_flush_hilo", {hi_o, lo_o}, {prev.hi, prev.lo});

      // Reset at T+20 of a MULT clears HI/LO and discards the op.
      issue(MDU_MULT, 32'd3, 32'd3);
      for (int c = 1; c < 20; c++) tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      @(negedge clk);
      check("midreset_hilo", {hi_o, lo_o}, 64'd0);
      check("midreset_busy", 64'(busy_o), 64'd0);
      dones = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done_o) dones++;
         tick();
      end
      check("midreset_no_done", 64'(dones), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
